// File: rtl/result_tx_ctrl_pkg.sv
// Shared constants, FSM state encoding and arbitration grant encoding for
// the result/echo UART transmit controller.
package result_tx_ctrl_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ECHO,
    ST_CONV,
    ST_SEND_DIG,
    ST_SEND_CR,
    ST_SEND_LF,
    ST_WAIT_TX
  } state_t;

  typedef enum logic {
    GRANT_ECHO,
    GRANT_RESULT
  } grant_t;

endpackage

// File: rtl/digit_fifo.sv
// Small circular buffer holding the BCD digits of one result, most
// significant first. Pushes while full and pops while empty are ignored.
module digit_fifo #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: the storage array is reset along with the pointers so an aborted
  // result can never leave stale digits visible at dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register see the pre-edge
      // values of the others, independent of statement order.
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/result_tx_ctrl.sv
// Shares one UART transmitter between an echo byte stream and decimal RPN
// results, sequencing the external binary-to-BCD converter for each result.
module result_tx_ctrl
  import result_tx_ctrl_pkg::*;
#(
  parameter bit APPEND_CRLF = 1'b1,
  parameter int NDIG        = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        echo_valid,
  input  logic [7:0]  echo_data,
  output logic        echo_ready,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  output logic        res_ready,
  output logic [15:0] conv_din,
  output logic        conv_wen,
  input  logic [3:0]  conv_digit,
  input  logic        conv_leading_zero,
  input  logic        conv_sending,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy
);

  localparam int CW = $clog2(NDIG + 1);

  state_t         state_q, state_d;
  state_t         ret_q, ret_d;
  logic           skip_q, skip_d;
  logic           seen_q, seen_d;
  grant_t         last_grant_q;
  logic [7:0]     echo_byte_q;
  logic [7:0]     tx_data_q;
  logic [7:0]     send_byte;
  logic           grant_echo;
  logic           grant_res;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_empty;
  logic [3:0]     fifo_din;
  logic [3:0]     fifo_dout;
  logic [CW-1:0]  fifo_count;

  // Round-robin only matters on contention: last_grant records the winner of
  // the most recent cycle in which both sources were requesting.
  assign grant_echo = echo_valid && (!res_valid || last_grant_q == GRANT_RESULT);
  assign grant_res  = res_valid && !grant_echo;

  digit_fifo #(.DEPTH(NDIG), .WIDTH(4), .CW(CW)) u_digit_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
      skip_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      skip_q  <= skip_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    skip_d  = skip_q;
    seen_d  = seen_q;
    unique case (state_q)
      ST_IDLE: begin
        seen_d = 1'b0;
        if (grant_echo)     state_d = ST_ECHO;
        else if (grant_res) state_d = ST_CONV;
      end
      ST_ECHO: if (!tx_busy) begin
        state_d = ST_WAIT_TX;
        ret_d   = ST_IDLE;
        skip_d  = 1'b1;
      end
      ST_CONV: begin
        if (conv_sending)  seen_d  = 1'b1;
        else if (seen_q)   state_d = ST_SEND_DIG;
      end
      ST_SEND_DIG: begin
        if (fifo_empty) begin
          state_d = APPEND_CRLF ? ST_SEND_CR : ST_IDLE;
        end else if (!tx_busy) begin
          state_d = ST_WAIT_TX;
          ret_d   = ST_SEND_DIG;
          skip_d  = 1'b1;
        end
      end
      ST_SEND_CR: if (!tx_busy) begin
        state_d = ST_WAIT_TX;
        ret_d   = ST_SEND_LF;
        skip_d  = 1'b1;
      end
      ST_SEND_LF: if (!tx_busy) begin
        state_d = ST_WAIT_TX;
        ret_d   = ST_IDLE;
        skip_d  = 1'b1;
      end
      ST_WAIT_TX: begin
        // The first cycle is skipped so the transmitter has time to raise busy.
        if (skip_q)        skip_d  = 1'b0;
        else if (!tx_busy) state_d = ret_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block can infer a latch.
    echo_ready = 1'b0;
    res_ready  = 1'b0;
    tx_start   = 1'b0;
    send_byte  = tx_data_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_din   = conv_digit;
    unique case (state_q)
      ST_IDLE: begin
        // Ready is combinational from the request; rst_n keeps it low in reset.
        echo_ready = rst_n && grant_echo;
        res_ready  = rst_n && grant_res;
      end
      ST_ECHO: begin
        send_byte = echo_byte_q;
        tx_start  = !tx_busy;
      end
      ST_CONV: begin
        if (conv_sending) begin
          fifo_push = !conv_leading_zero;
        end else if (seen_q && fifo_count == '0) begin
          fifo_push = 1'b1;
          fifo_din  = '0;
        end
      end
      ST_SEND_DIG: begin
        send_byte = ASCII_ZERO | {4'h0, fifo_dout};
        tx_start  = !fifo_empty && !tx_busy;
        fifo_pop  = tx_start;
      end
      ST_SEND_CR: begin
        send_byte = ASCII_CR;
        tx_start  = !tx_busy;
      end
      ST_SEND_LF: begin
        send_byte = ASCII_LF;
        tx_start  = !tx_busy;
      end
      default: ;
    endcase
  end

  assign tx_data = tx_start ? send_byte : tx_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_RESULT;
      echo_byte_q  <= '0;
      tx_data_q    <= '0;
      conv_din     <= '0;
      conv_wen     <= 1'b0;
    end else begin
      conv_wen <= res_ready;
      if (echo_ready) begin
        echo_byte_q <= echo_data;
        if (res_valid) last_grant_q <= GRANT_ECHO;
      end
      if (res_ready) begin
        conv_din <= res_data;
        if (echo_valid) last_grant_q <= GRANT_RESULT;
      end
      if (tx_start) tx_data_q <= send_byte;
    end
  end

endmodule

// File: tb/tb_result_tx_ctrl.sv
// Scoreboard bench for result_tx_ctrl with converter and UART stand-ins.
module tb_result_tx_ctrl;

  localparam int NDIG = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        echo_valid = 1'b0;
  logic [7:0]  echo_data = '0;
  logic        echo_ready;
  logic        res_valid = 1'b0;
  logic [15:0] res_data = '0;
  logic        res_ready;
  logic [15:0] conv_din;
  logic        conv_wen;
  logic [3:0]  conv_digit = '0;
  logic        conv_leading_zero = 1'b0;
  logic        conv_sending = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          bytes_sent = 0;
  logic [7:0]  last_tx = '0;
  logic [15:0] exp_conv = '0;
  bit          tb_last_res = 1'b1;
  int          busy_len = 10;
  int          long_idx = -1;
  int          uart_cnt = 0;

  always #5 clk = ~clk;

  result_tx_ctrl #(.APPEND_CRLF(1'b1), .NDIG(NDIG)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .echo_valid        (echo_valid),
    .echo_data         (echo_data),
    .echo_ready        (echo_ready),
    .res_valid         (res_valid),
    .res_data          (res_data),
    .res_ready         (res_ready),
    .conv_din          (conv_din),
    .conv_wen          (conv_wen),
    .conv_digit        (conv_digit),
    .conv_leading_zero (conv_leading_zero),
    .conv_sending      (conv_sending),
    .tx_data           (tx_data),
    .tx_start          (tx_start),
    .tx_busy           (tx_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_echo_ready"}, 32'(echo_ready), 0);
    check({tag, "_res_ready"},  32'(res_ready), 0);
    check({tag, "_conv_din"},   32'(conv_din), 0);
    check({tag, "_conv_wen"},   32'(conv_wen), 0);
    check({tag, "_tx_data"},    32'(tx_data), 0);
    check({tag, "_tx_start"},   32'(tx_start), 0);
  endtask

  // Decimal text of a result, no leading zeros, followed by CR LF.
  task automatic push_result_bytes(input int v);
    int digs[$];
    int x;
    x = v;
    do begin
      digs.push_front(x % 10);
      x = x / 10;
    end while (x != 0);
    foreach (digs[i]) exp_q.push_back(8'h30 + 8'(digs[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Monitor / scoreboard: compares every transmitted byte against the queue.
  initial begin : monitor
    logic prev_wen;
    prev_wen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_tx  = '0;
        prev_wen = 1'b0;
      end else begin
        if (conv_wen) begin
          check("conv_din", 32'(conv_din), 32'(exp_conv));
          check("conv_wen_one_cycle", 32'(prev_wen), 0);
        end
        prev_wen = conv_wen;
        if (tx_start) begin
          check("start_while_busy", 32'(tx_busy), 0);
          check("tx_expected_pending", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
          bytes_sent++;
          last_tx = tx_data;
        end else if (tx_busy) begin
          check("tx_data_hold", 32'(tx_data), 32'(last_tx));
        end
      end
    end
  end

  // Converter stand-in: emits NDIG BCD digits MSB first after a short delay.
  initial begin : converter
    int v;
    int d;
    int p;
    bit lead;
    forever begin
      @(negedge clk);
      if (rst_n && conv_wen) begin
        v = int'(conv_din);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        lead = 1'b1;
        p = 1;
        for (int i = 1; i < NDIG; i++) p = p * 10;
        for (int i = 0; i < NDIG; i++) begin
          d = (v / p) % 10;
          p = p / 10;
          lead = lead && (d == 0);
          conv_digit        = 4'(d);
          conv_leading_zero = lead;
          conv_sending      = 1'b1;
          @(posedge clk);
          #1;
        end
        conv_sending      = 1'b0;
        conv_leading_zero = 1'b0;
        conv_digit        = '0;
      end
    end
  end

  // UART stand-in: busy rises the cycle after a start and lasts busy_len cycles.
  initial begin : uart
    int len;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        len = (uart_cnt == long_idx) ? 100 : busy_len;
        uart_cnt++;
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  task automatic wait_ready(input bit sel_res, input int budget);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      got = sel_res ? res_ready : echo_ready;
    end
    if (sel_res) check("res_accept", 32'(got), 1);
    else         check("echo_accept", 32'(got), 1);
    @(posedge clk);
    #1;
    if (sel_res) res_valid = 1'b0;
    else         echo_valid = 1'b0;
  endtask

  // Reference arbitration: on contention the source not granted last time wins.
  task automatic request(input bit do_echo, input bit do_res,
                         input logic [7:0] eb, input logic [15:0] rv);
    bit echo_first;
    echo_first = do_echo && (!do_res || tb_last_res);
    if (echo_first) begin
      exp_q.push_back(eb);
      if (do_res) push_result_bytes(int'(rv));
    end else begin
      if (do_res) push_result_bytes(int'(rv));
      if (do_echo) exp_q.push_back(eb);
    end
    if (do_echo && do_res) tb_last_res = !echo_first;
    if (do_res) exp_conv = rv;
    @(posedge clk);
    #1;
    echo_data  = eb;
    res_data   = rv;
    echo_valid = do_echo;
    res_valid  = do_res;
    fork
      begin if (do_echo) wait_ready(1'b0, 3000); end
      begin if (do_res)  wait_ready(1'b1, 3000); end
    join
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 32'(exp_q.size()), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n;
    n = 0;
    while (bytes_sent < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("bytes_reached", 32'(bytes_sent >= target), 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int n;
    int kind;
    int v;

    // Requests held high during reset must not be acknowledged.
    rst_n      = 1'b0;
    echo_valid = 1'b1;
    res_valid  = 1'b1;
    echo_data  = 8'hAA;
    res_data   = 16'h1234;
    repeat (3) @(negedge clk);
    check_zero("reset");
    echo_valid = 1'b0;
    res_valid  = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    busy_len = 10;
    request(1'b0, 1'b1, 8'h00, 16'd123);
    wait_drain(3000);
    request(1'b0, 1'b1, 8'h00, 16'd0);
    wait_drain(3000);
    request(1'b0, 1'b1, 8'h00, 16'd65535);
    wait_drain(3000);

    // Contention twice in a row: echo first, then result first.
    request(1'b1, 1'b1, 8'h2B, 16'd7);
    wait_drain(3000);
    request(1'b1, 1'b1, 8'h2B, 16'd7);
    wait_drain(3000);

    // Long busy on the third byte with an echo raised meanwhile.
    base     = bytes_sent;
    long_idx = uart_cnt + 2;
    request(1'b0, 1'b1, 8'h00, 16'd12345);
    wait_bytes(base + 3, 3000);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h21);
    echo_data  = 8'h21;
    echo_valid = 1'b1;
    wait_ready(1'b0, 3000);
    check("echo_after_lf", 32'(bytes_sent - base), 7);
    wait_drain(3000);
    long_idx = -1;

    // Reset pulse while a digit is being started.
    request(1'b0, 1'b1, 8'h00, 16'd54321);
    n = 0;
    while (!tx_start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("digit_start_seen", 32'(tx_start), 1);
    rst_n = 1'b0;
    #1 check_zero("mid_reset");
    exp_q.delete();
    tb_last_res = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    request(1'b0, 1'b1, 8'h00, 16'd42);
    wait_drain(3000);

    // Randomised mix of echoes, results and contention.
    for (int k = 0; k < 14; k++) begin
      kind     = $urandom_range(0, 2);
      busy_len = $urandom_range(1, 12);
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 65535);
      request(kind != 1, kind != 0, 8'($urandom), 16'(v));
      wait_drain(5000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_tx_ctrl.md
RESULT_TX_CTRL -- requirements
Module: result_tx_ctrl

Interface
REQ-001 Parameter: APPEND_CRLF, default 1, meaning: send CR (0x0D) then LF (0x0A) after each result's digits.
REQ-002 Parameter: NDIG, default 5, meaning: maximum decimal digits of a 16-bit result and the depth of the digit buffer.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  the single system clock; all logic is on the rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: echo_valid  in  1  an echo byte is pending.
REQ-007 Port: echo_data  in  8  the echo byte.
REQ-008 Port: echo_ready  out  1  the echo byte is accepted in this cycle.
REQ-009 Port: res_valid  in  1  an RPN result is pending.
REQ-010 Port: res_data  in  16  the unsigned result.
REQ-011 Port: res_ready  out  1  the result is accepted in this cycle.
REQ-012 Port: conv_din  out  16  the value passed to the digit converter.
REQ-013 Port: conv_wen  out  1  one-cycle load strobe to the converter.
REQ-014 Port: conv_digit  in  4  BCD digit, most significant first.
REQ-015 Port: conv_leading_zero  in  1  the current digit is a leading zero.
REQ-016 Port: conv_sending  in  1  the converter is emitting one digit per cycle.
REQ-017 Port: tx_data  out  8  the byte to the UART transmitter.
REQ-018 Port: tx_start  out  1  one-cycle start strobe to the UART transmitter.
REQ-019 Port: tx_busy  in  1  the UART transmitter is busy; it rises the cycle after tx_start.

Function
REQ-020 The block shall share the UART transmitter between the echo stream and the result stream, and shall sequence the digit converter for results.
REQ-021 The FSM shall have the states IDLE, ECHO, CONV, SEND_DIG, SEND_CR, SEND_LF and WAIT_TX.
REQ-022 Arbitration shall occur only in IDLE: if exactly one request is valid it is granted; if both are valid, the source not granted last wins (last_grant resets to RESULT, so echo wins first).
REQ-023 echo_ready and res_ready shall be asserted only in IDLE for the granted source, each as a single-cycle acceptance.
REQ-024 An accepted result transmission shall never be interrupted; echo requests wait until the FSM returns to IDLE.
REQ-025 On echo accept: the byte is latched, state goes to ECHO, and ECHO issues the byte by the tx rule (REQ-031).
REQ-026 On result accept: conv_din is latched, conv_wen is high for exactly the next cycle, then state goes to CONV.
REQ-027 In CONV: each cycle with conv_sending=1 and conv_leading_zero=0, conv_digit is pushed into the digit buffer.
REQ-028 CONV shall exit on the falling edge of conv_sending, detected only after it was seen high.
REQ-029 If the digit buffer is empty when CONV exits (result is 0), a single digit 0 shall be pushed.
REQ-030 SEND_DIG shall pop digits in order, sending each as ASCII 0x30|digit.
REQ-031 After the buffer empties: if APPEND_CRLF=1, go SEND_CR then SEND_LF then IDLE; otherwise go to IDLE.
REQ-032 Tx rule: tx_start shall pulse for one cycle only when tx_busy=0, with tx_data valid that cycle and held until the next start.
REQ-033 Tx rule: after each tx_start, WAIT_TX shall skip one cycle, then wait for tx_busy=0 before continuing.
REQ-034 Digit buffer pushes beyond NDIG shall be dropped, and a push and pop never occur in the same cycle.
REQ-035 Output latency shall be: the first tx_start of a result no earlier than 1 cycle after conv_sending falls; an echo tx_start 1 cycle after echo accept.

Reset
REQ-036 While rst_n=0 the FSM shall be in IDLE.
REQ-037 While rst_n=0, the digit buffer and its pointers shall be cleared.
REQ-038 While rst_n=0, last_grant shall be RESULT.
REQ-039 While rst_n=0, every output shall be 0: echo_ready, res_ready, conv_din, conv_wen, tx_data, tx_start.
REQ-040 Reset mid-operation shall abort immediately, with no further tx_start until a new accept after reset.

Structure
REQ-041 The shared package shall hold the constants ASCII_ZERO=0x30, ASCII_CR=0x0D, ASCII_LF=0x0A, the FSM state encodings, and the grant encoding.
REQ-042 The sub-module digit_fifo (NDIG x 4-bit, push/pop/empty/count, async active-low reset) shall be used; all other logic stays in result_tx_ctrl.

Verification
REQ-043 res_data=123 with tx_busy modelled as 10 cycles -> conv_wen for one cycle with conv_din=123; tx bytes 0x31 0x32 0x33 0x0D 0x0A.
REQ-044 res_data=0 -> tx bytes 0x30 0x0D 0x0A, with exactly one digit sent.
REQ-045 res_data=65535 -> tx bytes 0x36 0x35 0x35 0x33 0x35 0x0D 0x0A, with no dropped digits.
REQ-046 echo 0x2B and res 7 valid in the same IDLE cycle -> 0x2B first, then 0x37 0x0D 0x0A; a repeat of the same case grants the result first.
REQ-047 tx_busy held high for 100 cycles mid-result -> no extra tx_start and tx_data stable; an echo_valid raised meanwhile gets echo_ready only after LF.
REQ-048 rst_n pulsed low during SEND_DIG -> all outputs 0 in the same cycle; then res 42 -> 0x34 0x32 0x0D 0x0A.
